fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction fetch front end of the 3-stage pipeline; producer side of the IF/EX pipeline register.
- Owns the PC and issues one-outstanding-request reads to instruction memory.
- Presents pc_next/machine_code plus a bubble flag to the IF/EX register, and reacts to branch redirects and back-end stalls from execute.

Parameters:
RESET_PC  32'h0000_0000  PC fetched first after reset
NOP_INSN  32'h0000_0013  instruction driven when no valid fetch (addi x0,x0,0)

Ports:
clock          input   1   clock
reset          input   1   synchronous, active-high reset
branch_taken   input   1   redirect from execute, valid this cycle
branch_target  input   32  redirect PC; bits [1:0] ignored (forced 0)
stall_in       input   1   back end not accepting this cycle; held instruction is re-presented
imem_req       output  1   single-cycle read request, always accepted by memory
imem_addr      output  32  word-aligned read address, valid when imem_req=1
imem_rvalid    input   1   read data valid (1+ cycles after imem_req)
imem_rdata     input   32  read data
pc_next        output  32  PC of presented instruction (to IF/EX)
machine_code   output  32  presented instruction (to IF/EX)
fetch_bubble   output  1   1 = nothing valid presented; ORed into IF/EX stall

Behaviour:
- Reset: synchronous, active-high, highest priority.
  - pc_reg=RESET_PC, buffer=NOP_INSN, state=REQ.
  - While reset is high: imem_req=0, fetch_bubble=1, machine_code=NOP_INSN, pc_next=RESET_PC.
  - Responses in flight at reset are dropped (imem shares reset).
- States: REQ, WAIT, VALID, DRAIN. Outputs are combinational from state/regs:
  - pc_next = pc_reg.
  - machine_code = buffer in VALID, else NOP_INSN.
  - fetch_bubble = (state!=VALID).
- REQ:
  - imem_req = !branch_taken; imem_addr = pc_reg.
  - branch_taken: pc_reg<=target, stay REQ, no request issued.
  - Otherwise -> WAIT.
- WAIT:
  - imem_rvalid & !branch_taken: buffer<=imem_rdata -> VALID.
  - imem_rvalid & branch_taken: data discarded, pc_reg<=target -> REQ.
  - !imem_rvalid & branch_taken: pc_reg<=target -> DRAIN.
  - Else stay.
- VALID: instruction is consumed in any cycle with !stall_in & !branch_taken.
  - branch_taken (wins over stall_in): buffer discarded, pc_reg<=target -> REQ.
  - stall_in: hold pc_reg and buffer, stay VALID; same instruction is re-presented next cycle.
  - Consumed: same cycle imem_req=1, imem_addr=pc_reg+4, pc_reg<=pc_reg+4 -> WAIT.
- DRAIN: waits for the stale response and discards it.
  - imem_rvalid: discard -> REQ.
  - Further branch_taken: pc_reg<=new target (latest wins), stay DRAIN until rvalid.
- Arithmetic: pc_reg+4 wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000). Targets are masked with ~32'h3.
- imem_rvalid in REQ or VALID is a protocol error: ignored, no state change.
- At most one request outstanding at any time.
- Throughput with 1-cycle memory latency and no stalls: one instruction per 2 cycles.

Test Plan:
- Reset then run (latency 1, mem[i]=0x00100093+i):
  - First request addr 0x0 in the cycle after reset deasserts.
  - VALID presents pc_next=0x0 / 0x00100093.
  - Then request 0x4; pc_next=0x4 two cycles later.
  - fetch_bubble alternates 1/0.
- stall_in held 3 cycles in VALID at pc 0x8:
  - pc_next=0x8 and machine_code stable for 3 cycles, no imem_req.
  - Request 0xC issued the cycle stall_in drops.
- Branch in VALID (target 0x103):
  - No request that cycle.
  - Next cycle REQ with imem_addr=0x100.
  - Presented instruction is mem[0x100]; the old buffer is never presented.
- Branch while WAIT, latency 4, target 0x200:
  - Stale response for the old pc is discarded; fetch_bubble stays 1.
  - Next request addr 0x200.
  - Second branch to 0x300 during DRAIN -> request addr 0x300.
- Wrap: branch to 0xFFFF_FFFC, consume:
  - Next imem_addr=0x0000_0000.
- Reset mid-WAIT:
  - fetch_bubble=1, machine_code=0x00000013 during reset.
  - First request after release is RESET_PC.
  - No stale data is ever presented.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch front end: owns the PC, keeps at most one instruction
// memory read in flight, and presents pc_next/machine_code plus a bubble flag
// to the IF/EX pipeline register. Redirects come from execute via
// branch_taken, and back-end stalls arrive on stall_in.
//
// state  | meaning
// -------+---------------------------------------------------------------
// REQ    | issue a read for pc_reg this cycle (no read if redirected)
// WAIT   | read for pc_reg outstanding, waiting for imem_rvalid
// VALID  | buffer holds the instruction at pc_reg, presented to IF/EX
// DRAIN  | redirected while a read was outstanding; drop its response
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        stall_in,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_next,
  output logic [31:0] machine_code,
  output logic        fetch_bubble
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      state;
  state_t      state_d;
  logic [31:0] pc_reg;
  logic [31:0] pc_d;
  logic [31:0] buffer;
  logic [31:0] buffer_d;

  logic [31:0] pc_plus4;
  logic [31:0] target_aligned;

  // pc_reg + 4 wraps naturally at 2^32
  assign pc_plus4       = pc_reg + 32'd4;
  assign target_aligned = branch_target & ~32'h3;

  // State, PC and instruction buffer registers; reset has priority
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_REQ;
      pc_reg <= RESET_PC;
      buffer <= NOP_INSN;
    end else begin
      state  <= state_d;
      pc_reg <= pc_d;
      buffer <= buffer_d;
    end
  end

  // Next-state, next-PC and buffer capture; rvalid outside WAIT/DRAIN is ignored
  always_comb begin
    state_d  = state;
    pc_d     = pc_reg;
    buffer_d = buffer;
    unique case (state)
      S_REQ: begin
        if (branch_taken) begin
          pc_d = target_aligned;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (branch_taken) begin
            pc_d    = target_aligned;
            state_d = S_REQ;
          end else begin
            buffer_d = imem_rdata;
            state_d  = S_VALID;
          end
        end else if (branch_taken) begin
          pc_d    = target_aligned;
          state_d = S_DRAIN;
        end
      end
      S_VALID: begin
        if (branch_taken) begin
          pc_d    = target_aligned;
          state_d = S_REQ;
        end else if (!stall_in) begin
          pc_d    = pc_plus4;
          state_d = S_WAIT;
        end
      end
      S_DRAIN: begin
        // latest redirect wins; the stale response only ends the drain
        if (branch_taken) begin
          pc_d = target_aligned;
        end
        if (imem_rvalid) begin
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // Outputs; reset forces the idle view even before the registers are cleared
  always_comb begin
    imem_req     = 1'b0;
    imem_addr    = pc_reg;
    pc_next      = pc_reg;
    machine_code = NOP_INSN;
    fetch_bubble = 1'b1;
    if (reset) begin
      pc_next = RESET_PC;
    end else begin
      unique case (state)
        S_REQ: begin
          imem_req = !branch_taken;
        end
        S_VALID: begin
          machine_code = buffer;
          fetch_bubble = 1'b0;
          // consuming the instruction launches the next sequential read at once
          imem_req     = !stall_in && !branch_taken;
          imem_addr    = pc_plus4;
        end
        default: begin
          imem_req = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a variable-latency instruction memory
// model, a queue of PCs expected to be consumed by the back end, a cycle table
// for the basic run/stall/branch sequence and hand-written redirect sequences.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        stall_in = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc_next;
  logic [31:0] machine_code;
  logic        fetch_bubble;

  int n_tests = 0;
  int n_fail  = 0;

  // memory model state
  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic [31:0] mem_a   = 32'h0;
  logic        mem_rv  = 1'b0;
  logic [31:0] mem_rd  = 32'h0;
  logic        spur    = 1'b0;

  // scoreboard of PCs expected to be consumed, in order
  logic [31:0] exp_q[$];
  logic        sb_en = 1'b0;

  typedef struct {
    logic        br;
    logic [31:0] tgt;
    logic        stall;
    logic        spur;
    logic        req;
    logic [31:0] addr;
    logic        bub;
    logic [31:0] pc;
    logic [31:0] mc;
  } vec_t;

  vec_t vec[16];

  always #5 clock = ~clock;

  assign imem_rvalid = mem_rv | spur;
  assign imem_rdata  = spur ? 32'hBAD0_BAD0 : mem_rd;

  fetch_stage #(
    .RESET_PC(32'h0000_0000),
    .NOP_INSN(32'h0000_0013)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .stall_in     (stall_in),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .pc_next      (pc_next),
    .machine_code (machine_code),
    .fetch_bubble (fetch_bubble)
  );

  function automatic logic [31:0] memword(input logic [31:0] a);
    return 32'h0010_0093 + {2'b00, a[31:2]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // instruction memory: answers each request mem_lat cycles later, shares reset
  initial begin
    forever begin
      @(posedge clock);
      if (reset) begin
        mem_cnt = 0;
        mem_rv <= 1'b0;
      end else begin
        if (imem_req) begin
          chk("one_outstanding", 32'(mem_cnt), 32'd0);
          mem_cnt = mem_lat;
          mem_a   = imem_addr;
        end
        mem_rv <= 1'b0;
        if (mem_cnt > 0) begin
          mem_cnt = mem_cnt - 1;
          if (mem_cnt == 0) begin
            mem_rv <= 1'b1;
            mem_rd <= memword(mem_a);
          end
        end
      end
    end
  end

  // output monitor: reset view, no stale data, in-order consumption
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_bubble", 32'(fetch_bubble), 32'd1);
        chk("rst_code", machine_code, NOP);
        chk("rst_pc", pc_next, 32'h0);
      end else begin
        if (!fetch_bubble) chk("presented_insn", machine_code, memword(pc_next));
        if (sb_en && !fetch_bubble && !stall_in && !branch_taken) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_consume @%0t: got pc %h, expected none", $time, pc_next);
          end else begin
            chk("consume_pc", pc_next, exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset = 1'b1;
    branch_taken = 1'b0;
    stall_in = 1'b0;
    spur = 1'b0;
    repeat (2) cyc();
    reset = 1'b0;
  endtask

  task automatic wait_req(input string name, input logic [31:0] addr, input bit chk_bub, input int max);
    bit seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clock);
      if (imem_req) begin
        seen = 1'b1;
        chk(name, imem_addr, addr);
      end else begin
        if (chk_bub) chk({name, "_bubble"}, 32'(fetch_bubble), 32'd1);
        cyc();
      end
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got no imem_req within %0d cycles, expected addr %h", name, max, addr);
    end
  endtask

  task automatic wait_drain(input int max);
    for (int i = 0; i < max && exp_q.size() != 0; i++) begin
      @(negedge clock);
    end
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic vec_t mkv(input logic br, input logic [31:0] tgt, input logic stall,
                               input logic sp, input logic req, input logic [31:0] addr,
                               input logic bub, input logic [31:0] pc, input logic [31:0] mc);
    vec_t v;
    v.br = br; v.tgt = tgt; v.stall = stall; v.spur = sp; v.req = req;
    v.addr = addr; v.bub = bub; v.pc = pc; v.mc = mc;
    return v;
  endfunction

  initial begin
    //            br  tgt           stl sp  req addr          bub pc            mc
    vec[0]  = mkv(0, 32'h0,        0, 0, 1, 32'h0000_0000, 1, 32'h0000_0000, NOP);
    vec[1]  = mkv(0, 32'h0,        0, 0, 0, 32'h0,         1, 32'h0000_0000, NOP);
    vec[2]  = mkv(0, 32'h0,        0, 0, 1, 32'h0000_0004, 0, 32'h0000_0000, 32'h0010_0093);
    vec[3]  = mkv(0, 32'h0,        0, 0, 0, 32'h0,         1, 32'h0000_0004, NOP);
    vec[4]  = mkv(0, 32'h0,        0, 0, 1, 32'h0000_0008, 0, 32'h0000_0004, 32'h0010_0094);
    vec[5]  = mkv(0, 32'h0,        0, 0, 0, 32'h0,         1, 32'h0000_0008, NOP);
    vec[6]  = mkv(0, 32'h0,        1, 0, 0, 32'h0,         0, 32'h0000_0008, 32'h0010_0095);
    vec[7]  = mkv(0, 32'h0,        1, 1, 0, 32'h0,         0, 32'h0000_0008, 32'h0010_0095);
    vec[8]  = mkv(0, 32'h0,        1, 0, 0, 32'h0,         0, 32'h0000_0008, 32'h0010_0095);
    vec[9]  = mkv(0, 32'h0,        0, 0, 1, 32'h0000_000C, 0, 32'h0000_0008, 32'h0010_0095);
    vec[10] = mkv(0, 32'h0,        0, 0, 0, 32'h0,         1, 32'h0000_000C, NOP);
    vec[11] = mkv(1, 32'h0000_0103, 0, 0, 0, 32'h0,        0, 32'h0000_000C, 32'h0010_0096);
    vec[12] = mkv(0, 32'h0,        0, 1, 1, 32'h0000_0100, 1, 32'h0000_0100, NOP);
    vec[13] = mkv(0, 32'h0,        0, 0, 0, 32'h0,         1, 32'h0000_0100, NOP);
    vec[14] = mkv(0, 32'h0,        0, 0, 1, 32'h0000_0104, 0, 32'h0000_0100, 32'h0010_00D3);
    vec[15] = mkv(0, 32'h0,        0, 0, 0, 32'h0,         1, 32'h0000_0104, NOP);

    // reset, sequential run, stall, branch in VALID (latency 1)
    mem_lat = 1;
    sb_en = 1'b1;
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'h0000_0004);
    exp_q.push_back(32'h0000_0008);
    exp_q.push_back(32'h0000_0100);
    do_reset();
    for (int i = 0; i < 16; i++) begin
      branch_taken  = vec[i].br;
      branch_target = vec[i].tgt;
      stall_in      = vec[i].stall;
      spur          = vec[i].spur;
      @(negedge clock);
      chk($sformatf("v%0d_req", i), 32'(imem_req), 32'(vec[i].req));
      if (vec[i].req) chk($sformatf("v%0d_addr", i), imem_addr, vec[i].addr);
      chk($sformatf("v%0d_bubble", i), 32'(fetch_bubble), 32'(vec[i].bub));
      chk($sformatf("v%0d_pc", i), pc_next, vec[i].pc);
      chk($sformatf("v%0d_code", i), machine_code, vec[i].mc);
      cyc();
    end
    branch_taken = 1'b0;
    spur = 1'b0;
    stall_in = 1'b1;
    wait_drain(2);

    // branch while WAIT with latency 4, then a second redirect during DRAIN
    mem_lat = 4;
    exp_q.push_back(32'h0000_0300);
    do_reset();
    wait_req("wait_first_req", 32'h0, 1'b1, 2);
    cyc();
    branch_taken = 1'b1;
    branch_target = 32'h0000_0200;
    @(negedge clock);
    chk("wait_branch_bubble", 32'(fetch_bubble), 32'd1);
    cyc();
    branch_taken = 1'b0;
    wait_req("drain_then_200", 32'h0000_0200, 1'b1, 10);
    cyc();
    branch_taken = 1'b1;
    branch_target = 32'h0000_02F0;
    cyc();
    branch_target = 32'h0000_0300;
    cyc();
    branch_taken = 1'b0;
    wait_req("drain_latest_300", 32'h0000_0300, 1'b1, 10);
    cyc();
    wait_drain(12);

    // wrap: unaligned redirect to the top word, consume, next address wraps to 0
    mem_lat = 1;
    exp_q.push_back(32'hFFFF_FFFC);
    do_reset();
    branch_taken = 1'b1;
    branch_target = 32'hFFFF_FFFF;
    @(negedge clock);
    chk("req_branch_noreq", 32'(imem_req), 32'd0);
    cyc();
    branch_taken = 1'b0;
    wait_req("wrap_top_req", 32'hFFFF_FFFC, 1'b1, 3);
    cyc();
    wait_req("wrap_next_req", 32'h0000_0000, 1'b0, 4);
    cyc();
    @(negedge clock);
    chk("wrap_pc", pc_next, 32'h0000_0000);
    wait_drain(2);

    // reset in the middle of an outstanding read at a non-reset PC
    mem_lat = 4;
    do_reset();
    branch_taken = 1'b1;
    branch_target = 32'h0000_0400;
    cyc();
    branch_taken = 1'b0;
    wait_req("pre_reset_req", 32'h0000_0400, 1'b1, 3);
    cyc();
    cyc();
    reset = 1'b1;
    @(negedge clock);
    chk("midwait_rst_bubble", 32'(fetch_bubble), 32'd1);
    chk("midwait_rst_code", machine_code, NOP);
    repeat (3) cyc();
    mem_lat = 1;
    exp_q.push_back(32'h0000_0000);
    reset = 1'b0;
    wait_req("post_reset_req", 32'h0000_0000, 1'b1, 1);
    cyc();
    wait_drain(6);
    stall_in = 1'b1;
    repeat (2) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
